// File: rtl/posit_divsqrt_arbiter.sv
// Round-robin sharing of one posit div/sqrt unit among NUM_REQ requesters, one op in flight.
// Grant-to-response is 2 cycles with a combinational unit; an unaccepted response holds RESP and blocks new grants.
package posit_pkg;
  typedef enum logic [1:0] {POSIT16 = 2'd0, POSIT8 = 2'd1, POSIT32 = 2'd2, POSIT64 = 2'd3} posit_format_e;
  typedef enum logic [1:0] {DIV = 2'd0, SQRT = 2'd1} operation_e;
  typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RDN = 2'd2, RUP = 2'd3} roundmode_e;
  typedef struct packed {
    logic nar;
    logic div_zero;
    logic inexact;
  } status_t;

  function automatic int posit_width(posit_format_e fmt);
    case (fmt)
      POSIT8:  return 8;
      POSIT32: return 32;
      POSIT64: return 64;
      default: return 16;
    endcase
  endfunction
endpackage

module posit_divsqrt_arbiter #(
  parameter posit_pkg::posit_format_e pFormat = posit_pkg::posit_format_e'(0),
  parameter int NUM_REQ = 4,
  localparam int WIDTH = posit_pkg::posit_width(pFormat),
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NUM_REQ-1:0]                     req_valid_i,
  output logic [NUM_REQ-1:0]                     req_ready_o,
  input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0]     req_operands_i,
  input  posit_pkg::operation_e [NUM_REQ-1:0]    req_op_i,
  input  posit_pkg::roundmode_e [NUM_REQ-1:0]    req_rnd_mode_i,
  input  logic [NUM_REQ-1:0]                     req_tag_i,
  output logic [NUM_REQ-1:0]                     resp_valid_o,
  input  logic [NUM_REQ-1:0]                     resp_ready_i,
  output logic [WIDTH-1:0]                       resp_result_o,
  output posit_pkg::status_t                     resp_status_o,
  output logic                                   resp_tag_o,
  output logic [1:0][WIDTH-1:0]                  unit_operands_o,
  output posit_pkg::operation_e                  unit_op_o,
  output posit_pkg::roundmode_e                  unit_rnd_mode_o,
  output logic                                   unit_tag_o,
  output logic                                   unit_in_valid_o,
  input  logic                                   unit_in_ready_i,
  input  logic                                   unit_out_valid_i,
  output logic                                   unit_out_ready_o,
  input  logic [WIDTH-1:0]                       unit_result_i,
  input  posit_pkg::status_t                     unit_status_i,
  input  logic                                   unit_tag_i,
  output logic                                   unit_flush_o,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q;
  logic [IDW-1:0]        rr_q, id_q;
  logic [1:0][WIDTH-1:0] opnd_q;
  posit_pkg::operation_e op_q;
  posit_pkg::roundmode_e rnd_q;
  logic                  tag_q;
  logic [WIDTH-1:0]      res_q;
  posit_pkg::status_t    status_q;
  logic                  rtag_q;

  logic                  arb_en, gnt_vld;
  logic [IDW-1:0]        gnt_id, idx;
  logic [IDW:0]          idx_full;
  logic                  unused_unit_tag;

  // Ownership lives in id_q, so the tag coming back from the unit carries no information.
  assign unused_unit_tag = unit_tag_i;

  assign arb_en = !flush_i && ((state_q == IDLE) || ((state_q == RESP) && resp_ready_i[id_q]));

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    idx      = '0;
    idx_full = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_full = {1'b0, rr_q} + (IDW+1)'(i);
      if (idx_full >= (IDW+1)'(NUM_REQ)) idx_full = idx_full - (IDW+1)'(NUM_REQ);
      idx = idx_full[IDW-1:0];
      if (arb_en && !gnt_vld && req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_vld) req_ready_o[gnt_id] = 1'b1;
    resp_valid_o = '0;
    if ((state_q == RESP) && !flush_i) resp_valid_o[id_q] = 1'b1;
  end

  assign resp_result_o    = res_q;
  assign resp_status_o    = status_q;
  assign resp_tag_o       = rtag_q;
  assign unit_operands_o  = opnd_q;
  assign unit_op_o        = op_q;
  assign unit_rnd_mode_o  = rnd_q;
  assign unit_tag_o       = tag_q;
  assign unit_in_valid_o  = (state_q == ISSUE);
  assign unit_out_ready_o = (state_q == ISSUE) || (state_q == WAIT);
  assign unit_flush_o     = flush_i;
  assign busy_o           = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      opnd_q   <= '0;
      op_q     <= posit_pkg::operation_e'(2'd0);
      rnd_q    <= posit_pkg::roundmode_e'(2'd0);
      tag_q    <= 1'b0;
      res_q    <= '0;
      status_q <= '0;
      rtag_q   <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      // A grant in RESP overrides the return to IDLE below, giving back-to-back issue.
      if (gnt_vld) begin
        opnd_q  <= req_operands_i[gnt_id];
        op_q    <= req_op_i[gnt_id];
        rnd_q   <= req_rnd_mode_i[gnt_id];
        tag_q   <= req_tag_i[gnt_id];
        id_q    <= gnt_id;
        rr_q    <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        state_q <= ISSUE;
      end
      case (state_q)
        IDLE: ;
        ISSUE: begin
          if (unit_in_ready_i) begin
            if (unit_out_valid_i) begin
              res_q    <= unit_result_i;
              status_q <= unit_status_i;
              rtag_q   <= tag_q;
              state_q  <= RESP;
            end else begin
              state_q  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (unit_out_valid_i) begin
            res_q    <= unit_result_i;
            status_q <= unit_status_i;
            rtag_q   <= tag_q;
            state_q  <= RESP;
          end
        end
        RESP: if (resp_ready_i[id_q] && !gnt_vld) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_divsqrt_arbiter.sv
// Directed bench for posit_divsqrt_arbiter with a switchable combinational / externally paced unit model.
module tb_posit_divsqrt_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                      flush;
  logic [N-1:0]              req_valid, req_ready, resp_valid, resp_ready, req_tag;
  logic [N-1:0][1:0][W-1:0]  req_operands;
  posit_pkg::operation_e [N-1:0] req_op;
  posit_pkg::roundmode_e [N-1:0] req_rnd;
  logic [W-1:0]              resp_result, unit_result;
  posit_pkg::status_t        resp_status, unit_status;
  logic                      resp_tag;
  logic [1:0][W-1:0]         unit_operands;
  posit_pkg::operation_e     unit_op;
  posit_pkg::roundmode_e     unit_rnd;
  logic                      unit_tag, unit_tag_ret, unit_in_valid, unit_in_ready;
  logic                      unit_out_valid, unit_out_ready, unit_flush, busy;

  logic                      comb_mode, ext_in_ready, ext_out_valid;
  logic [W-1:0]              ext_result;
  posit_pkg::status_t        ext_status;

  int n_assert = 0;
  int n_fail = 0;

  posit_divsqrt_arbiter #(.pFormat(posit_pkg::POSIT16), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_op_i(req_op), .req_rnd_mode_i(req_rnd), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_result_o(resp_result),
    .resp_status_o(resp_status), .resp_tag_o(resp_tag),
    .unit_operands_o(unit_operands), .unit_op_o(unit_op), .unit_rnd_mode_o(unit_rnd),
    .unit_tag_o(unit_tag), .unit_in_valid_o(unit_in_valid), .unit_in_ready_i(unit_in_ready),
    .unit_out_valid_i(unit_out_valid), .unit_out_ready_o(unit_out_ready),
    .unit_result_i(unit_result), .unit_status_i(unit_status), .unit_tag_i(unit_tag_ret),
    .unit_flush_o(unit_flush), .busy_o(busy)
  );

  // Stand-in for the divsqrt datapath: 1.0/2.0 is exact, anything else returns a+b as a fingerprint.
  function automatic logic [W-1:0] unit_model(logic [1:0][W-1:0] ops, posit_pkg::operation_e op);
    if (op == posit_pkg::DIV && ops[0] == 16'h4000 && ops[1] == 16'h5000) return 16'h3000;
    return ops[0] + ops[1];
  endfunction

  always_comb begin
    if (comb_mode) begin
      unit_in_ready  = 1'b1;
      unit_out_valid = unit_in_valid;
      unit_result    = unit_model(unit_operands, unit_op);
      unit_status    = '0;
    end else begin
      unit_in_ready  = ext_in_ready;
      unit_out_valid = ext_out_valid;
      unit_result    = ext_result;
      unit_status    = ext_status;
    end
  end
  assign unit_tag_ret = ~unit_tag;

  task automatic load_ops();
    for (int r = 0; r < N; r++) begin
      req_operands[r][0] = W'(16'h1000 * (r + 1));
      req_operands[r][1] = W'(16'h0010 * (r + 1));
      req_op[r]  = (r % 2 == 1) ? posit_pkg::SQRT : posit_pkg::DIV;
      req_rnd[r] = posit_pkg::roundmode_e'(r);
      req_tag[r] = r[0];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; resp_ready = '1;
    comb_mode = 1'b1; ext_in_ready = 1'b0; ext_out_valid = 1'b0; ext_result = '0; ext_status = '0;
    load_ops();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 0000", req_ready); end
    n_assert++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_valid: got %b exp 0000", resp_valid); end
    n_assert++; if ({unit_in_valid, unit_out_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_unit_hs: got %b exp 00", {unit_in_valid, unit_out_ready}); end
    n_assert++; if (unit_operands !== 32'h0) begin n_fail++; $display("FAIL reset_issue_reg: got %h exp 0", unit_operands); end
    @(posedge clk); #1;
    rst_n = 1'b1; comb_mode = 1'b0; ext_in_ready = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    n_assert++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if ({busy, unit_in_valid, unit_out_ready} !== 3'b101) begin n_fail++; $display("FAIL reset_in_wait: got %b exp 101", {busy, unit_in_valid, unit_out_ready}); end
    #1 rst_n = 1'b0;
    #1;
    n_assert++; if ({busy, unit_in_valid, unit_out_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_async: got %b exp 000", {busy, unit_in_valid, unit_out_ready}); end
    n_assert++; if ({resp_valid, req_ready} !== 8'h00) begin n_fail++; $display("FAIL reset_async_vld_rdy: got %b exp 0", {resp_valid, req_ready}); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_single_div();
    do_reset();
    req_operands[2][0] = 16'h4000; req_operands[2][1] = 16'h5000;
    req_op[2] = posit_pkg::DIV; req_tag[2] = 1'b1; req_valid = 4'b0100;
    @(negedge clk);
    n_assert++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL div_grant: got %b exp 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    n_assert++; if (unit_in_valid !== 1'b1) begin n_fail++; $display("FAIL div_in_valid: got %b exp 1", unit_in_valid); end
    n_assert++; if (unit_operands !== {16'h5000, 16'h4000}) begin n_fail++; $display("FAIL div_operands: got %h exp 50004000", unit_operands); end
    n_assert++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL div_early_resp: got %b exp 0000", resp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if (resp_valid !== 4'b0100) begin n_fail++; $display("FAIL div_resp_valid: got %b exp 0100", resp_valid); end
    n_assert++; if (resp_result !== 16'h3000) begin n_fail++; $display("FAIL div_result: got %h exp 3000", resp_result); end
    n_assert++; if (resp_tag !== 1'b1) begin n_fail++; $display("FAIL div_tag: got %b exp 1", resp_tag); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if ({busy, resp_valid} !== 5'b0) begin n_fail++; $display("FAIL div_idle: got %b exp 0", {busy, resp_valid}); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_rdy, exp_resp;
    int g, r;
    do_reset();
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      g = (c / 2) % N;
      r = (c / 2 + N - 1) % N;
      exp_rdy = '0; exp_resp = '0;
      if (c % 2 == 0) exp_rdy[g] = 1'b1;
      if (c >= 2 && c % 2 == 0) exp_resp[r] = 1'b1;
      @(negedge clk);
      n_assert++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant c%0d: got %b exp %b", c, req_ready, exp_rdy); end
      n_assert++; if (resp_valid !== exp_resp) begin n_fail++; $display("FAIL rr_resp c%0d: got %b exp %b", c, resp_valid, exp_resp); end
      if (exp_resp != '0) begin
        n_assert++; if (resp_result !== W'(16'h1010 * (r + 1))) begin n_fail++; $display("FAIL rr_result c%0d: got %h exp %h", c, resp_result, W'(16'h1010 * (r + 1))); end
        n_assert++; if (resp_tag !== r[0]) begin n_fail++; $display("FAIL rr_tag c%0d: got %b exp %b", c, resp_tag, r[0]); end
      end
      if (c % 2 == 1) begin
        n_assert++; if (unit_rnd !== posit_pkg::roundmode_e'(g)) begin n_fail++; $display("FAIL rr_rnd c%0d: got %0d exp %0d", c, unit_rnd, g); end
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0010;
    @(negedge clk);
    n_assert++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b exp 0010", req_ready); end
    @(posedge clk); #1; req_valid = '0; resp_ready = 4'b1101;
    @(posedge clk); #1; req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_assert++; if (resp_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_hold k%0d: got %b exp 0010", k, resp_valid); end
      n_assert++; if (resp_result !== 16'h2020) begin n_fail++; $display("FAIL bp_result k%0d: got %h exp 2020", k, resp_result); end
      n_assert++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant k%0d: got %b exp 0000", k, req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = '1;
    @(negedge clk);
    n_assert++; if ({resp_valid, req_ready} !== 8'b0010_0001) begin n_fail++; $display("FAIL bp_accept: got %b exp 00100001", {resp_valid, req_ready}); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    n_assert++; if ({busy, unit_in_valid} !== 2'b11) begin n_fail++; $display("FAIL bp_b2b_issue: got %b exp 11", {busy, unit_in_valid}); end
    n_assert++; if (unit_operands !== {16'h0010, 16'h1000}) begin n_fail++; $display("FAIL bp_b2b_ops: got %h exp 00101000", unit_operands); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_multicycle();
    do_reset();
    comb_mode = 1'b0; ext_result = 16'hBEEF;
    ext_status = '{nar: 1'b1, div_zero: 1'b0, inexact: 1'b1};
    req_valid = 4'b1000;
    @(negedge clk);
    n_assert++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mc_grant: got %b exp 1000", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; req_operands[3] = {16'hDEAD, 16'hDEAD}; req_tag[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ext_in_ready = (k == 2);
      @(negedge clk);
      n_assert++; if ({unit_in_valid, unit_out_ready} !== 2'b11) begin n_fail++; $display("FAIL mc_issue k%0d: got %b exp 11", k, {unit_in_valid, unit_out_ready}); end
      n_assert++; if (unit_operands !== {16'h0040, 16'h4000}) begin n_fail++; $display("FAIL mc_ops k%0d: got %h exp 00404000", k, unit_operands); end
      n_assert++; if (unit_tag !== 1'b1) begin n_fail++; $display("FAIL mc_unit_tag k%0d: got %b exp 1", k, unit_tag); end
      @(posedge clk); #1;
    end
    ext_in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ext_out_valid = (k == 2);
      @(negedge clk);
      n_assert++; if ({busy, unit_in_valid, unit_out_ready} !== 3'b101) begin n_fail++; $display("FAIL mc_wait k%0d: got %b exp 101", k, {busy, unit_in_valid, unit_out_ready}); end
      n_assert++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL mc_wait_resp k%0d: got %b exp 0000", k, resp_valid); end
      @(posedge clk); #1;
    end
    ext_out_valid = 1'b0;
    @(negedge clk);
    n_assert++; if (resp_valid !== 4'b1000) begin n_fail++; $display("FAIL mc_resp_valid: got %b exp 1000", resp_valid); end
    n_assert++; if (resp_result !== 16'hBEEF) begin n_fail++; $display("FAIL mc_result: got %h exp beef", resp_result); end
    n_assert++; if (resp_status !== 3'b101) begin n_fail++; $display("FAIL mc_status: got %b exp 101", resp_status); end
    n_assert++; if (resp_tag !== 1'b1) begin n_fail++; $display("FAIL mc_tag: got %b exp 1", resp_tag); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    do_reset();
    comb_mode = 1'b0; ext_in_ready = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    n_assert++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fl_grant0: got %b exp 0001", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
    flush = 1'b1; ext_out_valid = 1'b1; req_valid = '1;
    @(negedge clk);
    n_assert++; if ({resp_valid, req_ready} !== 8'h00) begin n_fail++; $display("FAIL fl_wait_outputs: got %b exp 0", {resp_valid, req_ready}); end
    n_assert++; if (unit_flush !== 1'b1) begin n_fail++; $display("FAIL fl_unit_flush: got %b exp 1", unit_flush); end
    @(posedge clk); #1; flush = 1'b0; ext_out_valid = 1'b0;
    @(negedge clk);
    n_assert++; if ({busy, resp_valid} !== 5'b0) begin n_fail++; $display("FAIL fl_wait_idle: got %b exp 0", {busy, resp_valid}); end
    n_assert++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL fl_rr_kept1: got %b exp 0010", req_ready); end
    @(posedge clk); #1; req_valid = '0; ext_result = 16'h1234; ext_out_valid = 1'b1;
    @(posedge clk); #1; ext_out_valid = 1'b0; req_valid = '1; flush = 1'b1;
    @(negedge clk);
    n_assert++; if ({resp_valid, req_ready} !== 8'h00) begin n_fail++; $display("FAIL fl_resp_outputs: got %b exp 0", {resp_valid, req_ready}); end
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_assert++; if ({busy, resp_valid} !== 5'b0) begin n_fail++; $display("FAIL fl_resp_idle: got %b exp 0", {busy, resp_valid}); end
    n_assert++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fl_rr_kept2: got %b exp 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
  endtask

  initial begin
    flush = 1'b0; req_valid = '0; resp_ready = '1;
    comb_mode = 1'b0; ext_in_ready = 1'b0; ext_out_valid = 1'b0; ext_result = '0; ext_status = '0;
    load_ops();
    test_reset();
    test_single_div();
    test_round_robin();
    test_backpressure();
    test_multicycle();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
